// File: rtl/uart_rx_word_packer_if.sv
// Word output handshake between the UART byte packer and its consumer.
//
// Signals:
//   valid : producer holds an unconsumed word
//   ready : consumer accepts the word on this clock edge
//   word  : packed word, first received byte in the LSBs
//
// Modports:
//   master : the packer (drives valid/word, observes ready)
//   slave  : the consumer (observes valid/word, drives ready)
interface uart_rx_word_packer_if #(
    parameter int W = 16
) ();
    logic         valid;
    logic         ready;
    logic [W-1:0] word;

    modport master (
        output valid,
        output word,
        input  ready
    );

    modport slave (
        input  valid,
        input  word,
        output ready
    );
endinterface

// File: rtl/uart_rx_word_packer.sv
// Packs NBYTES consecutive UART bytes into one word and offers it to the
// processor side through a valid/ready handshake.
//
// The first byte received lands in the LSBs. If too many baud ticks pass
// before the next byte arrives, the stale partial word is discarded.
//
// A word completed while an earlier word is still waiting is dropped, and the
// sticky overrun flag is set.
//
// Ports:
//   i_clk          : system clock
//   i_reset        : asynchronous, active-high reset
//   i_rx_done_tick : one-cycle strobe from the receiver, i_rx_data valid
//   i_rx_data      : received byte
//   i_s_tick       : baud oversampling tick, the same one the receiver uses
//   i_clr_err      : clears the sticky o_overrun flag
//   o_byte_cnt     : number of bytes currently held in the partial word
//   o_overrun      : sticky, a completed word was dropped
//   o_timeout      : one-cycle pulse, a partial word was discarded
//   word_if        : word output handshake (master side)
//
// State table:
//   state   | meaning
//   IDLE    | no partial word held; the tick counter is idle at zero
//   COLLECT | 1..NBYTES-1 bytes held; counting ticks since the last byte
module uart_rx_word_packer #(
    parameter int DBIT          = 8,
    parameter int NBYTES        = 2,
    parameter int TIMEOUT_TICKS = 1024
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_rx_done_tick,
    input  logic [DBIT-1:0]           i_rx_data,
    input  logic                      i_s_tick,
    input  logic                      i_clr_err,
    output logic [$clog2(NBYTES):0]   o_byte_cnt,
    output logic                      o_overrun,
    output logic                      o_timeout,
    uart_rx_word_packer_if.master     word_if
);

    localparam int WORD_W = NBYTES * DBIT;
    localparam int CNT_W  = $clog2(NBYTES) + 1;
    // The width only has to hold TIMEOUT_TICKS-1, because the counter is
    // cleared on the tick that would otherwise take it past that value.
    localparam int TICK_W = $clog2(TIMEOUT_TICKS);

    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(NBYTES - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TIMEOUT_TICKS - 1);

    generate
        if (NBYTES < 2) begin : g_bad_nbytes
            $error("uart_rx_word_packer: NBYTES must be >= 2");
        end
        if (TIMEOUT_TICKS < 2) begin : g_bad_timeout
            $error("uart_rx_word_packer: TIMEOUT_TICKS must be >= 2");
        end
    endgenerate

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;

    logic [WORD_W-1:0]   asm_q;
    logic [WORD_W-1:0]   full_word;
    logic [CNT_W-1:0]    byte_cnt_q;
    logic [TICK_W-1:0]   tick_cnt_q;

    logic [WORD_W-1:0]   word_q;
    logic                valid_q;
    logic                overrun_q;
    logic                timeout_q;

    logic                byte_load;
    logic                word_done;
    logic                timeout_hit;
    logic                tick_clr;
    logic                tick_inc;
    logic                drop;

    // Assembly register with the incoming byte merged into its slot. On the
    // final byte this is the complete word, written to the output register
    // in the same edge.
    always_comb begin
        full_word = asm_q;
        full_word[int'(byte_cnt_q) * DBIT +: DBIT] = i_rx_data;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        byte_load   = 1'b0;
        word_done   = 1'b0;
        timeout_hit = 1'b0;
        tick_clr    = 1'b0;
        tick_inc    = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_rx_done_tick) begin
                    byte_load = 1'b1;
                    tick_clr  = 1'b1;
                    state_d   = COLLECT;
                end
            end

            COLLECT: begin
                // A byte takes priority over a coincident timeout tick.
                if (i_rx_done_tick) begin
                    byte_load = 1'b1;
                    tick_clr  = 1'b1;
                    if (byte_cnt_q == LAST_BYTE) begin
                        word_done = 1'b1;
                        state_d   = IDLE;
                    end
                end else if (i_s_tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        timeout_hit = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        tick_inc = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Assembly datapath. A completed or timed-out word leaves the register
    // cleared, ready for the next byte 0.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            asm_q      <= '0;
            byte_cnt_q <= '0;
            tick_cnt_q <= '0;
        end else begin
            if (word_done || timeout_hit) begin
                asm_q      <= '0;
                byte_cnt_q <= '0;
            end else if (byte_load) begin
                asm_q      <= full_word;
                byte_cnt_q <= byte_cnt_q + CNT_W'(1);
            end

            if (tick_clr || timeout_hit) begin
                tick_cnt_q <= '0;
            end else if (tick_inc) begin
                tick_cnt_q <= tick_cnt_q + TICK_W'(1);
            end
        end
    end

    // A word is dropped only when the previous word is still held and is not
    // being taken on this same edge.
    assign drop = word_done && valid_q && !word_if.ready;

    // Output register. It is separate from the assembly register, so the
    // next word can be collected while this one waits for the consumer.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            word_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (word_done && !drop) begin
                word_q  <= full_word;
                valid_q <= 1'b1;
            end else if (valid_q && word_if.ready) begin
                valid_q <= 1'b0;
            end

            // If a drop and a clear arrive together, the set wins.
            if (drop) begin
                overrun_q <= 1'b1;
            end else if (i_clr_err) begin
                overrun_q <= 1'b0;
            end

            timeout_q <= timeout_hit;
        end
    end

    assign word_if.valid = valid_q;
    assign word_if.word  = word_q;
    assign o_byte_cnt    = byte_cnt_q;
    assign o_overrun     = overrun_q;
    assign o_timeout     = timeout_q;

endmodule

// File: tb/tb_uart_rx_word_packer.sv
module tb_uart_rx_word_packer;

    localparam int DBIT = 8;
    localparam int NB   = 2;
    localparam int TO   = 32;
    localparam int W    = NB * DBIT;

    logic            i_clk;
    logic            i_reset;
    logic            i_rx_done_tick;
    logic [DBIT-1:0] i_rx_data;
    logic            i_s_tick;
    logic            i_clr_err;
    logic [1:0]      o_byte_cnt;
    logic            o_overrun;
    logic            o_timeout;

    uart_rx_word_packer_if #(.W(W)) wif ();

    uart_rx_word_packer #(
        .DBIT(DBIT),
        .NBYTES(NB),
        .TIMEOUT_TICKS(TO)
    ) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .i_rx_done_tick(i_rx_done_tick),
        .i_rx_data(i_rx_data),
        .i_s_tick(i_s_tick),
        .i_clr_err(i_clr_err),
        .o_byte_cnt(o_byte_cnt),
        .o_overrun(o_overrun),
        .o_timeout(o_timeout),
        .word_if(wif)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;
    int timeout_pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bytes held in a list-like accumulator, the number of
    // ticks elapsed since the last byte, and the word waiting for the consumer.
    int          m_held;
    logic [W-1:0] m_partial;
    int          m_idle_ticks;
    logic        m_valid;
    logic [W-1:0] m_word;
    logic        m_overrun;
    logic        m_timeout;

    always @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            m_held = 0; m_partial = '0; m_idle_ticks = 0;
            m_valid = 1'b0; m_word = '0; m_overrun = 1'b0; m_timeout = 1'b0;
        end else begin
            logic         finished;
            logic         dropped;
            logic         expired;
            logic [W-1:0] done_word;
            finished = 1'b0; dropped = 1'b0; expired = 1'b0; done_word = '0;
            if (i_rx_done_tick) begin
                m_partial = m_partial | (W'(i_rx_data) << (DBIT * m_held));
                m_held++;
                m_idle_ticks = 0;
                if (m_held == NB) begin
                    finished  = 1'b1;
                    done_word = m_partial;
                    m_held    = 0;
                    m_partial = '0;
                end
            end else if (m_held > 0 && i_s_tick) begin
                m_idle_ticks++;
                if (m_idle_ticks == TO) begin
                    expired = 1'b1;
                    m_held = 0; m_partial = '0; m_idle_ticks = 0;
                end
            end
            if (finished && m_valid && !wif.ready) begin
                dropped = 1'b1;
            end else if (finished) begin
                m_word  = done_word;
                m_valid = 1'b1;
            end else if (m_valid && wif.ready) begin
                m_valid = 1'b0;
            end
            if (dropped) m_overrun = 1'b1;
            else if (i_clr_err) m_overrun = 1'b0;
            m_timeout = expired;
        end
    end

    always @(negedge i_clk) begin
        if (!i_reset) begin
            check("valid", 32'(wif.valid), 32'(m_valid));
            if (m_valid) check("word", 32'(wif.word), 32'(m_word));
            check("byte_cnt", 32'(o_byte_cnt), 32'(m_held));
            check("overrun", 32'(o_overrun), 32'(m_overrun));
            check("timeout", 32'(o_timeout), 32'(m_timeout));
            if (o_timeout) timeout_pulses++;
        end
    end

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic tick);
        i_rx_done_tick = 1'b1;
        i_rx_data      = b;
        i_s_tick       = tick;
        cyc();
        i_rx_done_tick = 1'b0;
        i_s_tick       = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"},    32'(wif.valid),  32'd0);
        check({tag, "_word"},     32'(wif.word),   32'd0);
        check({tag, "_byte_cnt"}, 32'(o_byte_cnt), 32'd0);
        check({tag, "_overrun"},  32'(o_overrun),  32'd0);
        check({tag, "_timeout"},  32'(o_timeout),  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 1'b1; i_rx_done_tick = 1'b0; i_rx_data = '0;
        i_s_tick = 1'b0; i_clr_err = 1'b0; wif.ready = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        check_all_zero("reset");
        #2 i_reset = 1'b0;
        cyc();

        // Basic word, consumer always ready.
        wif.ready = 1'b1;
        send_byte(8'h34, 1'b0);
        send_byte(8'h12, 1'b0);
        check("t1_valid", 32'(wif.valid), 32'd1);
        check("t1_word", 32'(wif.word), 32'h1234);
        cyc();
        check("t1_valid_drop", 32'(wif.valid), 32'd0);
        check("t1_overrun", 32'(o_overrun), 32'd0);

        // Stalled consumer: second word dropped.
        wif.ready = 1'b0;
        send_byte(8'hCD, 1'b0);
        send_byte(8'hAB, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        check("t2_word_held", 32'(wif.word), 32'hABCD);
        check("t2_overrun_set", 32'(o_overrun), 32'd1);
        i_clr_err = 1'b1;
        cyc();
        i_clr_err = 1'b0;
        check("t2_overrun_clr", 32'(o_overrun), 32'd0);
        wif.ready = 1'b1;
        cyc();
        wif.ready = 1'b0;
        check("t2_consumed", 32'(wif.valid), 32'd0);

        // Final byte arrives on the same edge the held word is taken.
        send_byte(8'hCD, 1'b0);
        send_byte(8'hAB, 1'b0);
        send_byte(8'h66, 1'b0);
        wif.ready = 1'b1;
        send_byte(8'h55, 1'b0);
        wif.ready = 1'b0;
        check("t3_valid", 32'(wif.valid), 32'd1);
        check("t3_word", 32'(wif.word), 32'h5566);
        check("t3_overrun", 32'(o_overrun), 32'd0);
        wif.ready = 1'b1;
        cyc();

        // Timeout after TO ticks with no second byte.
        send_byte(8'h77, 1'b0);
        check("t4_byte_cnt_one", 32'(o_byte_cnt), 32'd1);
        timeout_pulses = 0;
        for (int i = 0; i < TO; i++) begin
            i_s_tick = 1'b1;
            cyc();
        end
        i_s_tick = 1'b0;
        check("t4_timeout_now", 32'(o_timeout), 32'd1);
        repeat (3) cyc();
        check("t4_pulses", 32'(timeout_pulses), 32'd1);
        check("t4_byte_cnt_zero", 32'(o_byte_cnt), 32'd0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h01, 1'b0);
        check("t4_word", 32'(wif.word), 32'h0102);
        cyc();

        // Byte coincides with the terminal tick: byte wins.
        send_byte(8'h10, 1'b0);
        timeout_pulses = 0;
        for (int i = 0; i < TO - 1; i++) begin
            i_s_tick = 1'b1;
            cyc();
        end
        send_byte(8'h20, 1'b1);
        check("t5_valid", 32'(wif.valid), 32'd1);
        check("t5_word", 32'(wif.word), 32'h2010);
        repeat (3) cyc();
        check("t5_no_timeout", 32'(timeout_pulses), 32'd0);

        // Reset mid-word with a word held.
        wif.ready = 1'b0;
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        check("t6_pre_valid", 32'(wif.valid), 32'd1);
        #2 i_reset = 1'b1;
        #1;
        check_all_zero("t6_reset");
        @(posedge i_clk);
        #3 i_reset = 1'b0;
        cyc();
        wif.ready = 1'b1;
        send_byte(8'hEF, 1'b0);
        send_byte(8'hBE, 1'b0);
        check("t6_word", 32'(wif.word), 32'hBEEF);
        check("t6_timeout", 32'(o_timeout), 32'd0);
        repeat (3) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_word_packer.md
Name: uart_rx_word_packer

Overview:
Sits directly downstream of the UART receiver. Consumes its byte strobe and data, packs NBYTES consecutive bytes into one word (first byte in the LSBs), and presents the word to the processor side through a valid/ready handshake. An inter-byte timeout, counted in baud oversampling ticks, discards stale partial words. An overrun flag reports words lost because the consumer stalled.

Parameters:
DBIT, 8, bits per received byte (matches receiver data width)
NBYTES, 2, bytes per output word; output width = NBYTES*DBIT; must be >= 2
TIMEOUT_TICKS, 1024, s_ticks without a new byte before a partial word is discarded; must be >= 2

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous, active-high reset
i_rx_done_tick  in  1  one-cycle strobe from receiver: i_rx_data is a valid byte
i_rx_data  in  DBIT  received byte
i_s_tick  in  1  baud oversampling tick (same tick that drives the receiver)
i_ready  in  1  consumer accepts o_word this cycle
i_clr_err  in  1  clears sticky o_overrun
o_valid  out  1  o_word holds an unconsumed word
o_word  out  NBYTES*DBIT  packed word
o_byte_cnt  out  clog2(NBYTES)+1  bytes currently held in the partial word
o_overrun  out  1  sticky: a completed word was dropped
o_timeout  out  1  one-cycle pulse: a partial word was discarded

Behaviour:
- Reset (async, i_reset high): state=IDLE; assembly register, byte counter and tick counter = 0; o_valid=0; o_word=0; o_overrun=0; o_timeout=0; o_byte_cnt=0. A reset in the middle of a word discards it; no o_timeout pulse.
- Assembly datapath and output register are separate, so a new word can be collected while o_valid is held.
- States:
  - IDLE: no partial word.
    - i_rx_done_tick: byte 0 -> bits [DBIT-1:0]; byte_cnt=1; tick counter=0; go to COLLECT.
  - COLLECT:
    - i_rx_done_tick: byte k -> bits [(k+1)*DBIT-1:k*DBIT]; byte_cnt+1; tick counter=0.
    - When byte NBYTES-1 arrives: word is complete; go to IDLE; byte_cnt=0.
    - Otherwise, on i_s_tick: tick counter+1. If counter==TIMEOUT_TICKS-1 and i_s_tick, discard the partial word, byte_cnt=0, pulse o_timeout the next cycle, go to IDLE.
    - i_rx_done_tick and the timeout tick in the same cycle: the byte wins, no timeout.
- Word completion (registered, one cycle):
  - Complete word is written to o_word and o_valid=1 on the clock edge that samples the final i_rx_done_tick. Latency from final strobe to o_valid = 1 cycle.
  - If o_valid=1 and i_ready=0 on that edge: new word dropped, o_word unchanged, o_overrun set.
  - If o_valid=1 and i_ready=1 on that edge: old word consumed, new word loaded, o_valid stays 1, no overrun.
- Handshake:
  - Transfer occurs on a posedge where o_valid=1 and i_ready=1; o_valid drops the next cycle unless a new word loads in the same cycle.
  - o_word is stable while o_valid=1 and i_ready=0.
  - i_ready while o_valid=0 has no effect.
- o_overrun:
  - Set by a drop; cleared by i_clr_err.
  - A drop and i_clr_err in the same cycle: set wins.
- o_timeout is high for exactly one cycle per discarded partial word.
- The tick counter width holds TIMEOUT_TICKS-1 and never wraps: it is compared and reset before overflow.
- i_rx_done_tick is assumed single-cycle; back-to-back strobes on consecutive cycles are each accepted.

Test Plan:
- NBYTES=2; bytes 0x34 then 0x12, i_ready=1 -> o_valid high for exactly 1 cycle, starting 1 cycle after the 0x12 strobe, with o_word=0x1234; o_overrun=0.
- i_ready=0; send 0xCD, 0xAB, then 0x11, 0x22 -> o_word holds 0xABCD, o_overrun=1; pulse i_clr_err -> o_overrun=0; raise i_ready -> 0xABCD consumed, o_valid=0.
- o_valid held with 0xABCD; final byte of 0x5566 arrives on the same edge as i_ready=1 -> o_word=0x5566, o_valid stays 1, o_overrun=0.
- TIMEOUT_TICKS=32; send 0x77, then 32 s_ticks with no byte -> o_timeout pulses once, o_byte_cnt=0; then send 0x02, 0x01 -> o_word=0x0102.
- Second byte strobe coincides with the 32nd s_tick -> no timeout; o_word formed from both bytes.
- Assert i_reset after one byte with o_valid=1 -> all outputs 0 immediately; next two bytes 0xEF, 0xBE -> o_word=0xBEEF.
